mult4b_seq: RTL and testbench



---
 rtl/mult4b_seq.sv | 151 +++++++++++++++
 tb/tb_mult4b_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult4b_seq.sv
// mult4b_seq: sequential 4x4 unsigned shift-and-add multiplier.
// One adder4b is time-shared over four add/shift steps, with operands and
// product exchanged over valid/ready handshakes.
// Optional build macro: MULT4B_SEQ_ZERO_SKIP_EN. When it is defined, a zero
// operand skips the RUN steps and the result appears one cycle after acceptance.

// Ripple-carry 4-bit adder, one full-adder cell per bit.
module adder4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];
endmodule

module mult4b_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] p,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] hi_q,    hi_d;
    logic [3:0] lo_q,    lo_d;
    logic [1:0] cnt_q,   cnt_d;

    // The only arithmetic resource: hi + mcand, carry-in tied low.
    logic [3:0] add_s;
    logic       add_cout;

    adder4b u_adder (
        .a    (hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // A zero operand may shortcut straight to DONE with a zero product.
    logic zero_op;
`ifdef MULT4B_SEQ_ZERO_SKIP_EN
    assign zero_op = (a == 4'd0) || (b == 4'd0);
`else
    assign zero_op = 1'b0;
`endif

    // Per-step partial sum: add the multiplicand only when the current multiplier bit is set.
    logic       step_c;
    logic [3:0] step_sum;

    always_comb begin
        step_c   = 1'b0;
        step_sum = hi_q;
        if (lo_q[0]) begin
            step_c   = add_cout;
            step_sum = add_s;
        end
    end

    // Next-state and datapath update: load on acceptance, shift-add in RUN, wait in DONE.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone marks acceptance.
                if (in_valid) begin
                    mcand_d = a;
                    hi_d    = 4'd0;
                    lo_d    = b;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                    if (zero_op) begin
                        lo_d    = 4'd0;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Product register shifts right by one with the carry entering at the top.
                hi_d  = {step_c, step_sum[3:1]};
                lo_d  = {step_sum[0], lo_q[3:1]};
                cnt_d = cnt_q + 2'd1;   // wraps 3->0 on the final step
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 4'd0;
            hi_q    <= 4'd0;
            lo_q    <= 4'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags come from the state register only, so no input reaches an output combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign p         = {hi_q, lo_q};
endmodule

// File: tb/tb_mult4b_seq.sv
// Testbench for mult4b_seq: directed scenarios plus an exhaustive operand sweep
// with random output backpressure, checked against plain a*b and expected latency.
module tb_mult4b_seq;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MULT4B_SEQ_ZERO_SKIP_EN
    localparam int ZERO_EDGES = 0;
`else
    localparam int ZERO_EDGES = 4;
`endif
    localparam int NORM_EDGES = 4;

    mult4b_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference: edges after acceptance until out_valid is visible.
    function automatic int exp_edges(input logic [3:0] x, input logic [3:0] y);
        return ((x == 4'd0) || (y == 4'd0)) ? ZERO_EDGES : NORM_EDGES;
    endfunction

    // Drive one operand pair from a negedge; return at the negedge after acceptance.
    task automatic start_op(input logic [3:0] x, input logic [3:0] y);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen (bounded); -1 on timeout.
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (!out_valid) k = -1;
    endtask

    // Complete the output handshake with one out_ready pulse.
    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 4'd0; b = 4'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (p !== 8'd0) begin n_err++; $display("FAIL reset_p got %h want 00", p); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        $display("reset released");
    endtask

    task automatic test_max();
        int k;
        out_ready = 1'b1;
        start_op(4'd15, 4'd15);
        out_ready = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL max_busy got %b want 1", busy); end
        wait_valid(k);
        n_cmp++; if (k != NORM_EDGES) begin n_err++; $display("FAIL max_latency got %0d want %0d", k, NORM_EDGES); end
        n_cmp++; if (p !== 8'hE1) begin n_err++; $display("FAIL max_p got %h want e1", p); end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL max_back_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        n_cmp++; if (p !== 8'hE1) begin n_err++; $display("FAIL max_p_hold got %h want e1", p); end
        $display("op 15*15 -> %h (edges %0d)", p, k);
    endtask

    task automatic test_stall();
        int k;
        out_ready = 1'b0;
        start_op(4'd9, 4'd7);
        wait_valid(k);
        n_cmp++; if (k != NORM_EDGES) begin n_err++; $display("FAIL stall_latency got %0d want %0d", k, NORM_EDGES); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || p !== 8'h3F) begin n_err++; $display("FAIL stall_hold cycle %0d got out_valid=%b p=%h want 1/3f", i, out_valid, p); end
        end
        finish_op();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        $display("op 9*7 -> %h after 10-cycle stall", p);
    endtask

    task automatic test_in_valid_hold();
        int k;
        out_ready = 1'b0;
        a = 4'd3; b = 4'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!out_valid && k < 20) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k != NORM_EDGES) begin n_err++; $display("FAIL hold_latency got %0d want %0d", k, NORM_EDGES); end
        n_cmp++; if (p !== 8'h0F) begin n_err++; $display("FAIL hold_p got %h want 0f", p); end
        a = 4'd6; b = 4'd7; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL hold_not_captured_in_done got in_ready=%b busy=%b want 1/0", in_ready, busy); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_second_accept got busy=%b want 1", busy); end
        wait_valid(k);
        n_cmp++; if (p !== 8'd42 || k != NORM_EDGES) begin n_err++; $display("FAIL hold_second_p got %h edges %0d want 2a edges %0d", p, k, NORM_EDGES); end
        finish_op();
        $display("op 3*5 -> 0f, then 6*7 -> %h", p);
    endtask

    task automatic test_zero();
        int k;
        logic [3:0] xs [2];
        logic [3:0] ys [2];
        xs[0] = 4'd0;  ys[0] = 4'd11;
        xs[1] = 4'd11; ys[1] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b0;
            start_op(xs[i], ys[i]);
            wait_valid(k);
            n_cmp++; if (k != exp_edges(xs[i], ys[i])) begin n_err++; $display("FAIL zero_latency %0d*%0d got %0d want %0d", xs[i], ys[i], k, exp_edges(xs[i], ys[i])); end
            n_cmp++; if (p !== 8'd0) begin n_err++; $display("FAIL zero_p %0d*%0d got %h want 00", xs[i], ys[i], p); end
            finish_op();
            $display("op %0d*%0d -> %h (edges %0d)", xs[i], ys[i], p, k);
        end
    endtask

    task automatic test_async_reset();
        int k;
        out_ready = 1'b0;
        start_op(4'd12, 4'd13);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || p !== 8'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset got out_valid=%b p=%h in_ready=%b busy=%b want 0/00/1/0", out_valid, p, in_ready, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(4'd2, 4'd3);
        wait_valid(k);
        n_cmp++; if (p !== 8'h06 || k != NORM_EDGES) begin n_err++; $display("FAIL after_reset_p got %h edges %0d want 06 edges %0d", p, k, NORM_EDGES); end
        finish_op();
        $display("op 12*13 aborted by reset, then 2*3 -> %h", p);
    endtask

    task automatic test_sweep();
        int k;
        int exp_p;
        int guard;
        logic rdy;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                // Idle gap: no result may appear without an acceptance.
                repeat ($urandom_range(0, 2)) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    @(negedge clk);
                end
                n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL sweep_idle got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
                exp_p = x * y;
                out_ready = 1'b0;
                start_op(4'(x), 4'(y));
                wait_valid(k);
                n_cmp++; if (k != exp_edges(4'(x), 4'(y))) begin n_err++; $display("FAIL sweep_latency %0d*%0d got %0d want %0d", x, y, k, exp_edges(4'(x), 4'(y))); end
                n_cmp++; if (p !== 8'(exp_p)) begin n_err++; $display("FAIL sweep_p %0d*%0d got %0d want %0d", x, y, p, exp_p); end
                // Random backpressure: valid must persist until a cycle with out_ready high.
                guard = 0;
                rdy   = 1'b0;
                while (!rdy && guard < 50) begin
                    rdy = 1'($urandom_range(0, 1));
                    out_ready = rdy;
                    @(posedge clk);
                    @(negedge clk);
                    guard++;
                    n_cmp++; if (out_valid !== !rdy) begin n_err++; $display("FAIL sweep_handshake %0d*%0d got out_valid=%b want %b", x, y, out_valid, !rdy); end
                end
                out_ready = 1'b0;
                n_cmp++; if (p !== 8'(exp_p)) begin n_err++; $display("FAIL sweep_p_hold %0d*%0d got %0d want %0d", x, y, p, exp_p); end
                $display("op %0d*%0d -> %0d (edges %0d, stall %0d)", x, y, p, k, guard - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_stall();
        test_in_valid_hold();
        test_zero();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
